// File: rtl/param_loader.sv
// UART-fed parameter RAM loader: SYNC header, descending-address payload writes.
// Define PARAM_LOADER_CSUM_EN to hold address 0 until a trailing XOR checksum byte matches.
module param_loader #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned FRAME_LEN   = 113,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk_LD,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] w_addr,
  output logic [7:0] w_data,
  output logic       write,
  output logic       read,
  output logic       busy,
  output logic       frame_ok,
  output logic       frame_err
);

  localparam logic [7:0]  LAST    = 8'(FRAME_LEN - 1);
  localparam logic [31:0] TMO_END = 32'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
`ifdef PARAM_LOADER_CSUM_EN
    S_CSUM = 2'd2,
`endif
    S_DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] tmo_q, tmo_d;
  logic [7:0]  w_addr_q, w_addr_d;
  logic [7:0]  w_data_q, w_data_d;
  logic        write_q, write_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;
`ifdef PARAM_LOADER_CSUM_EN
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  hold_q, hold_d;
`endif

  always_ff @(posedge clk_LD) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      tmo_q    <= 32'd0;
      w_addr_q <= 8'd0;
      w_data_q <= 8'd0;
      write_q  <= 1'b1;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
`ifdef PARAM_LOADER_CSUM_EN
      acc_q    <= 8'd0;
      hold_q   <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      write_q  <= write_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
`ifdef PARAM_LOADER_CSUM_EN
      acc_q    <= acc_d;
      hold_q   <= hold_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    write_d  = 1'b1;
    ok_d     = 1'b0;
    err_d    = 1'b0;
`ifdef PARAM_LOADER_CSUM_EN
    acc_d    = acc_q;
    hold_d   = hold_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (rx_done && rx_data == SYNC_BYTE) begin
          state_d = S_RECV;
          cnt_d   = LAST;
          tmo_d   = 32'd0;
`ifdef PARAM_LOADER_CSUM_EN
          acc_d   = 8'd0;
`endif
        end
      end
      S_RECV: begin
        if (rx_done) begin
          tmo_d = 32'd0;
          cnt_d = (cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1;
`ifdef PARAM_LOADER_CSUM_EN
          acc_d = acc_q ^ rx_data;
          if (cnt_q == 8'd0) begin
            hold_d  = rx_data;
            state_d = S_CSUM;
          end else begin
            write_d  = 1'b0;
            w_addr_d = cnt_q;
            w_data_d = rx_data;
          end
`else
          write_d  = 1'b0;
          w_addr_d = cnt_q;
          w_data_d = rx_data;
          if (cnt_q == 8'd0) begin
            state_d = S_DONE;
            ok_d    = 1'b1;
          end
`endif
        end else if (tmo_q == TMO_END) begin
          // Silence on the line: drop the frame, keep what was written.
          state_d = S_IDLE;
          err_d   = 1'b1;
          tmo_d   = 32'd0;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
`ifdef PARAM_LOADER_CSUM_EN
      S_CSUM: begin
        if (rx_done) begin
          tmo_d = 32'd0;
          if (rx_data == acc_q) begin
            write_d  = 1'b0;
            w_addr_d = 8'd0;
            w_data_d = hold_q;
            state_d  = S_DONE;
            ok_d     = 1'b1;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end else if (tmo_q == TMO_END) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          tmo_d   = 32'd0;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign w_addr    = w_addr_q;
  assign w_data    = w_data_q;
  assign write     = write_q;
  assign read      = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign frame_ok  = ok_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_param_loader.sv
// Directed bench for param_loader: frames, junk, timeout, boundary, reset.
// Checksum scenarios run when PARAM_LOADER_CSUM_EN is defined.
module tb_param_loader;

  localparam int T = 40;

  logic       clk_LD = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'd0;
  logic       rx_done = 1'b0;
  logic [7:0] w_addr, w_data;
  logic       write, read, busy, frame_ok, frame_err;

  param_loader #(
    .SYNC_BYTE(8'hA5),
    .FRAME_LEN(113),
    .TIMEOUT_CYC(T)
  ) dut (
    .clk_LD(clk_LD),
    .rst(rst),
    .rx_data(rx_data),
    .rx_done(rx_done),
    .w_addr(w_addr),
    .w_data(w_data),
    .write(write),
    .read(read),
    .busy(busy),
    .frame_ok(frame_ok),
    .frame_err(frame_err)
  );

  always #5 clk_LD = ~clk_LD;

  int checks = 0;
  int failures = 0;

  int         n_str = 0, n_ok = 0, n_err = 0, n_a0 = 0, n_dbl = 0;
  logic       prev_w = 1'b1;
  logic [7:0] last_a = 8'd0, last_d = 8'd0;
  logic [7:0] mem [256];

  always @(negedge clk_LD) begin
    if (write === 1'b0) begin
      n_str  <= n_str + 1;
      last_a <= w_addr;
      last_d <= w_data;
      mem[w_addr] <= w_data;
      if (w_addr == 8'd0) n_a0 <= n_a0 + 1;
      if (prev_w === 1'b0) n_dbl <= n_dbl + 1;
    end
    prev_w <= write;
    if (frame_ok === 1'b1) n_ok <= n_ok + 1;
    if (frame_err === 1'b1) n_err <= n_err + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_LD);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    cyc(1);
    rx_done = 1'b0;
    cyc(1);
  endtask

  task automatic chk_rst(input string p);
    chk({p, "_write"}, 32'(write), 32'd1);
    chk({p, "_read"}, 32'(read), 32'd1);
    chk({p, "_busy"}, 32'(busy), 32'd0);
    chk({p, "_addr"}, 32'(w_addr), 32'd0);
    chk({p, "_data"}, 32'(w_data), 32'd0);
    chk({p, "_ok"}, 32'(frame_ok), 32'd0);
    chk({p, "_err"}, 32'(frame_err), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  int s, o, e, a;

  initial begin
    // reset with an ignored SYNC byte on the line
    rst = 1'b1;
    cyc(2);
    rx_data = 8'hA5;
    rx_done = 1'b1;
    cyc(1);
    rx_done = 1'b0;
    chk_rst("reset");
    rst = 1'b0;
    cyc(1);
    chk("rst_rx_ignored_busy", 32'(busy), 32'd0);

    // junk bytes in IDLE
    s = n_str;
    send(8'h3C);
    send(8'h11);
    chk("idle_strobes", 32'(n_str - s), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_read", 32'(read), 32'd1);

    // full frame: 0x00..0x6F then 0xFF at address 0
    s = n_str; o = n_ok; e = n_err;
    rx_data = 8'hA5;
    rx_done = 1'b1;
    cyc(1);
    rx_done = 1'b0;
    chk("sync_read_low", 32'(read), 32'd0);
    chk("sync_busy", 32'(busy), 32'd1);
    cyc(1);
    for (int i = 0; i < 112; i++) send(8'(i));
    send(8'hFF);
`ifdef PARAM_LOADER_CSUM_EN
    send(8'hFF);
`endif
    chk("full_strobes", 32'(n_str - s), 32'd113);
    chk("full_last_addr", 32'(last_a), 32'd0);
    chk("full_last_data", 32'(last_d), 32'hFF);
    chk("full_ok", 32'(n_ok - o), 32'd1);
    chk("full_err", 32'(n_err - e), 32'd0);
    chk("full_read", 32'(read), 32'd1);
    chk("full_busy", 32'(busy), 32'd0);
    chk("full_mem112", 32'(mem[112]), 32'h00);
    chk("full_mem56", 32'(mem[56]), 32'h38);
    chk("full_mem1", 32'(mem[1]), 32'h6F);

    // timeout after 10 payload bytes, exact expiry cycle
    s = n_str; o = n_ok; e = n_err;
    send(8'hA5);
    for (int i = 0; i < 10; i++) send(8'h80 + 8'(i));
    cyc(T - 2);
    chk("tmo_pre_busy", 32'(busy), 32'd1);
    chk("tmo_pre_err", 32'(frame_err), 32'd0);
    cyc(1);
    chk("tmo_err_pulse", 32'(frame_err), 32'd1);
    chk("tmo_idle", 32'(busy), 32'd0);
    cyc(1);
    chk("tmo_err_single", 32'(frame_err), 32'd0);
    cyc(T);
    chk("tmo_strobes", 32'(n_str - s), 32'd10);
    chk("tmo_last_addr", 32'(last_a), 32'h67);
    chk("tmo_err_cnt", 32'(n_err - e), 32'd1);
    chk("tmo_ok_cnt", 32'(n_ok - o), 32'd0);

    // recovery frame
    s = n_str; o = n_ok;
    send(8'hA5);
    for (int i = 0; i < 112; i++) send(8'(i));
    send(8'hFF);
`ifdef PARAM_LOADER_CSUM_EN
    send(8'hFF);
`endif
    chk("rec_strobes", 32'(n_str - s), 32'd113);
    chk("rec_ok", 32'(n_ok - o), 32'd1);
    chk("rec_mem0", 32'(mem[0]), 32'hFF);

    // rx_done landing on the timeout terminal cycle
    s = n_str; e = n_err;
    send(8'hA5);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    cyc(T - 2);
    send(8'h44);
    chk("coin_strobes", 32'(n_str - s), 32'd4);
    chk("coin_err", 32'(n_err - e), 32'd0);
    chk("coin_busy", 32'(busy), 32'd1);
    chk("coin_addr", 32'(last_a), 32'h6D);
    chk("coin_data", 32'(last_d), 32'h44);
    cyc(T + 2);
    chk("coin_later_tmo", 32'(n_err - e), 32'd1);

    // reset after the 50th payload byte, rx_done during reset
    s = n_str; e = n_err;
    send(8'hA5);
    for (int i = 0; i < 50; i++) send(8'(i));
    rst = 1'b1;
    rx_data = 8'h5A;
    rx_done = 1'b1;
    cyc(1);
    rx_done = 1'b0;
    chk_rst("midrst");
    rst = 1'b0;
    send(8'h01);
    send(8'h02);
    chk("midrst_strobes", 32'(n_str - s), 32'd50);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_err", 32'(n_err - e), 32'd0);

`ifdef PARAM_LOADER_CSUM_EN
    // wrong checksum: address 0 must not be written
    s = n_str; o = n_ok; e = n_err; a = n_a0;
    send(8'hA5);
    for (int i = 0; i < 112; i++) send(8'(i));
    send(8'hFF);
    send(8'hFE);
    chk("bad_csum_strobes", 32'(n_str - s), 32'd112);
    chk("bad_csum_a0", 32'(n_a0 - a), 32'd0);
    chk("bad_csum_err", 32'(n_err - e), 32'd1);
    chk("bad_csum_ok", 32'(n_ok - o), 32'd0);
    chk("bad_csum_busy", 32'(busy), 32'd0);
`endif

    chk("no_back_to_back_strobes", 32'(n_dbl), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_loader.md
PARAM_LOADER -- requirements
Module: param_loader

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, frame header byte.
REQ-002 Parameter FRAME_LEN, default 113, payload bytes per frame, equal to the RAM depth.
REQ-003 Parameter TIMEOUT_CYC, default 50000, maximum clk_LD cycles allowed between received bytes inside a frame.
REQ-004 clk_LD  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 rx_data  in  8  byte from the UART receiver, valid only while rx_done=1.
REQ-007 rx_done  in  1  single-cycle byte-valid pulse from the UART receiver.
REQ-008 w_addr  out  8  parameter RAM write address.
REQ-009 w_data  out  8  parameter RAM write data.
REQ-010 write  out  1  RAM write strobe, active-low, one cycle per byte.
REQ-011 read  out  1  RAM read enable; 0 while a frame is in progress, 1 otherwise.
REQ-012 busy  out  1  1 in every state except IDLE.
REQ-013 frame_ok  out  1  one-cycle pulse on a successfully completed frame.
REQ-014 frame_err  out  1  one-cycle pulse on an aborted or rejected frame.

Function
REQ-015 States SHALL be IDLE, RECV, CSUM (only with the macro in REQ-030) and DONE.
REQ-016 In IDLE, rx_done with rx_data==SYNC_BYTE SHALL move to RECV, load byte counter cnt=FRAME_LEN-1, clear the timeout counter and clear the XOR accumulator; all other bytes SHALL be ignored.
REQ-017 In RECV, each rx_done SHALL, on the next cycle, present w_addr=cnt, w_data=rx_data and write=0 for exactly one cycle (latency 1), then decrement cnt.
REQ-018 Payload SHALL be written in descending address order (FRAME_LEN-1 down to 0), so address 0 (start flag) is always written last.
REQ-019 rx_done while cnt==0 in RECV SHALL end reception: go to DONE without the macro, or to CSUM with it.
REQ-020 DONE SHALL last one cycle, pulse frame_ok and return to IDLE.
REQ-021 read SHALL fall to 0 in the cycle after the SYNC byte is accepted, and SHALL return to 1 in the cycle the state returns to IDLE.
REQ-022 Timeout counter SHALL increment every cycle in RECV/CSUM and clear on each rx_done. On reaching TIMEOUT_CYC-1 without rx_done, the block SHALL pulse frame_err, go to IDLE and perform no further writes; bytes already written stay written.
REQ-023 If rx_done and timeout expiry occur in the same cycle, rx_done SHALL take priority and the timeout SHALL NOT fire.
REQ-024 A SYNC_BYTE value received inside RECV SHALL be treated as payload, not as a new header.
REQ-025 write SHALL never be 0 on two consecutive cycles, and SHALL stay 1 in IDLE and DONE.

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL enter IDLE with write=1, read=1, w_addr=0, w_data=0, busy=0, frame_ok=0, frame_err=0, cnt=0, timeout counter=0 and accumulator=0.
REQ-027 Reset mid-frame SHALL abort the frame with no write strobe and no frame_err pulse in the reset cycle or the following cycle.
REQ-028 rx_done in the same cycle as rst=1 SHALL be ignored.

Configuration
REQ-029 Macro PARAM_LOADER_CSUM_EN SHALL select checksum protection.
REQ-030 Macro defined:
- An XOR of all FRAME_LEN payload bytes SHALL be accumulated.
- The address-0 byte SHALL be held internally, not written in RECV.
- In CSUM, the next rx_done SHALL be compared with the accumulator. On a match, the held byte SHALL be written to address 0 (write=0 for one cycle), frame_ok SHALL pulse and the state SHALL return to IDLE. On a mismatch, frame_err SHALL pulse, address 0 SHALL NOT be written, and the state SHALL return to IDLE.
- CSUM SHALL obey the timeout of REQ-022.
REQ-031 Macro undefined: the CSUM state, accumulator and holding register SHALL be absent, and the address-0 byte SHALL be written directly in RECV.

Verification
REQ-032 Bench SHALL cover: A5 then bytes 0x00..0x6F, 0xFF -> 113 strobes, addresses 112..0, last strobe addr 0 data FF, frame_ok=1, read back to 1.
REQ-033 Bench SHALL cover: 0x3C, 0x11 in IDLE -> no strobes, busy=0, read=1.
REQ-034 Bench SHALL cover: A5 plus 10 bytes, then silence for TIMEOUT_CYC cycles -> 10 strobes, frame_err pulse, IDLE; a subsequent full frame completes normally.
REQ-035 Bench SHALL cover: rst asserted after the 50th payload byte -> no further strobes, all outputs at reset values the next cycle.
REQ-036 Bench SHALL cover, with PARAM_LOADER_CSUM_EN: a full frame with a correct checksum -> address 0 written after the checksum byte and frame_ok; the same frame with checksum^0x01 -> 112 strobes, no address-0 write, frame_err.
REQ-037 Bench SHALL cover: rx_done coincident with the timeout terminal cycle -> byte written and no frame_err.
